// File: rtl/triv_hash_accum_if.sv
// Stream and tag handshake bundle for triv_hash_accum.
// A word moves when in_valid & in_ready are both high at a rising edge; the tag
// is consumed when tag_valid & tag_ready are both high; valid never waits on ready.
interface triv_hash_accum_if;
    logic        start;
    logic [31:0] key_in;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        tag_valid;
    logic [31:0] tag_out;
    logic        tag_ready;

    modport master (
        output start, key_in, in_valid, in_data, in_last, tag_ready,
        input  in_ready, tag_valid, tag_out
    );

    modport slave (
        input  start, key_in, in_valid, in_data, in_last, tag_ready,
        output in_ready, tag_valid, tag_out
    );
endinterface

// File: rtl/triv_hash_accum.sv
// Polynomial hash over GF(2^32): acc <= (acc ^ word) * H per word, then
// tag = (acc ^ word_count) * H. Field polynomial x^32 + x^7 + x^3 + x^2 + 1.
module field_mult_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    localparam logic [32:0] POLY = 33'h1_0000_008D;

    logic [62:0] clmul;
    logic [62:0] red;

    always_comb begin
        clmul = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) clmul = clmul ^ ({31'd0, a} << i);
        end
        // Fold high bits down from the top so every reduction lands below the bit it clears.
        red = clmul;
        for (int i = 62; i >= 32; i--) begin
            if (red[i]) red = red ^ ({30'd0, POLY} << (i - 32));
        end
        p = red[31:0];
    end
endmodule

module triv_hash_accum #(
    parameter int PIPE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    triv_hash_accum_if.slave     bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABSORB = 3'd1,
        WAITW  = 3'd2,
        LEN    = 3'd3,
        WAITL  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam bit PIPED = (PIPE != 0);

    state_t      state, state_nx;
    logic [31:0] h, acc, cnt, prod_r, tag_r;
    logic [31:0] x, product;
    logic        last_r;
    logic        accept;
    logic        ready_c;

    field_mult_32 u_mult (
        .a (acc ^ x),
        .b (h),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        accept   = 1'b0;
        x        = bus.in_data;
        case (state)
            IDLE: ;
            ABSORB: begin
                ready_c = ~bus.start;
                accept  = bus.in_valid & ~bus.start;
                if (accept) begin
                    if (PIPED)            state_nx = WAITW;
                    else if (bus.in_last) state_nx = LEN;
                end
            end
            WAITW: state_nx = last_r ? LEN : ABSORB;
            LEN: begin
                x        = cnt;
                state_nx = PIPED ? WAITL : DONE;
            end
            WAITL: state_nx = DONE;
            DONE:  if (bus.tag_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A new key aborts whatever is in flight, including a word offered this cycle.
        if (bus.start) state_nx = ABSORB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h      <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod_r <= '0;
            tag_r  <= '0;
            last_r <= 1'b0;
        end else if (bus.start) begin
            h   <= bus.key_in;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                ABSORB: if (accept) begin
                    cnt    <= cnt + 32'd1;
                    last_r <= bus.in_last;
                    if (PIPED) prod_r <= product;
                    else       acc    <= product;
                end
                WAITW: acc <= prod_r;
                LEN: begin
                    if (PIPED) prod_r <= product;
                    else       tag_r  <= product;
                end
                WAITL: tag_r <= prod_r;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.tag_valid = (state == DONE);
    assign bus.tag_out   = tag_r;
    assign state_dbg     = state;
endmodule
